icache_nway: RTL and testbench



---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_plru.sv | 38 +++
 rtl/icache_nway.sv | 173 +++++++++++++++++
 tb/tb_icache_nway.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and size helpers for the N-way instruction cache.
// Optional perf counters in icache_nway are enabled with ICACHE_PERF_CNT_EN.
package icache_pkg;

  localparam int DEF_S_OFFSET = 5;
  localparam int DEF_S_INDEX  = 3;
  localparam int DEF_WAYS     = 4;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  function automatic int line_bits(input int s_offset);
    return 8 * (2 ** s_offset);
  endfunction

  function automatic int num_sets(input int s_index);
    return 2 ** s_index;
  endfunction

  function automatic int tag_bits(input int s_offset, input int s_index);
    return 32 - s_offset - s_index;
  endfunction

  function automatic int way_bits(input int ways);
    return $clog2(ways);
  endfunction

  function automatic logic [31:0] line_addr(
    input logic [31:0] a,
    input int          s_offset
  );
    return a & ~((32'h1 << s_offset) - 32'h1);
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU: heap-ordered node bits, 0 steers the victim left.
// Purely combinational; the caller muxes in the tree of the active set.
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic [WAYS-2:0]       i_tree,
  input  logic [$clog2(WAYS)-1:0] i_way,
  output logic [WAYS-2:0]       o_tree,
  output logic [$clog2(WAYS)-1:0] o_victim
);

  localparam int WAY_W = way_bits(WAYS);

  logic [WAY_W-1:0] n;
  logic             d;

  always_comb begin
    o_tree   = i_tree;
    o_victim = '0;
    n        = '0;
    d        = 1'b0;
    // Point every node on the accessed path away from it
    for (int l = 0; l < WAY_W; l++) begin
      d         = i_way[WAY_W-1-l];
      o_tree[n] = ~d;
      n         = WAY_W'(2 * int'(n) + 1 + int'(d));
    end
    n = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d                     = i_tree[n];
      o_victim[WAY_W-1-l] = d;
      n                     = WAY_W'(2 * int'(n) + 1 + int'(d));
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only icache with fill FSM and fence.i flush.
// Define ICACHE_PERF_CNT_EN to add hit_count/miss_count outputs.
module icache_nway
  import icache_pkg::*;
#(
  parameter int S_OFFSET = DEF_S_OFFSET,
  parameter int S_INDEX  = DEF_S_INDEX,
  parameter int WAYS     = DEF_WAYS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_read,
  input  logic [31:0]                    mem_address,
  output logic                           mem_resp,
  output logic [line_bits(S_OFFSET)-1:0] mem_rdata256,
  input  logic                           flush,
  output logic                           pmem_read,
  output logic [31:0]                    pmem_address,
  input  logic [line_bits(S_OFFSET)-1:0] pmem_rdata,
  input  logic                           pmem_resp
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
`endif
);

  localparam int S_LINE   = line_bits(S_OFFSET);
  localparam int NUM_SETS = num_sets(S_INDEX);
  localparam int S_TAG    = tag_bits(S_OFFSET, S_INDEX);
  localparam int WAY_W    = way_bits(WAYS);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_line_addr;
  logic [WAY_W-1:0]    r_victim;
  logic                r_flush_pend;

  logic [S_LINE-1:0]   r_data  [WAYS][NUM_SETS];
  logic [S_TAG-1:0]    r_tag   [WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] r_valid [WAYS];
  logic [WAYS-2:0]     r_plru  [NUM_SETS];

  logic [S_INDEX-1:0]  w_idx;
  logic [S_INDEX-1:0]  w_fill_idx;
  logic [S_INDEX-1:0]  w_set;
  logic [S_TAG-1:0]    w_tag;
  logic [S_TAG-1:0]    w_fill_tag;
  logic [WAYS-1:0]     w_hit_vec;
  logic [WAY_W-1:0]    w_hit_way;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_acc_way;
  logic [WAY_W-1:0]    w_plru_victim;
  logic [WAYS-2:0]     w_plru_next;
  logic                w_hit;
  logic                w_miss;
  logic                w_fill_done;
  logic                w_clear_all;
  logic                w_unused;

  assign w_idx      = mem_address[S_OFFSET +: S_INDEX];
  assign w_tag      = mem_address[31 -: S_TAG];
  assign w_fill_idx = r_line_addr[S_OFFSET +: S_INDEX];
  assign w_fill_tag = r_line_addr[31 -: S_TAG];
  assign w_unused   = ^mem_address[S_OFFSET-1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hit_vec[g] = mem_read & r_valid[g][w_idx]
                        & (r_tag[g][w_idx] == w_tag);
  end

  always_comb begin
    w_hit_way = '0;
    w_victim  = w_plru_victim;
    for (int w = 0; w < WAYS; w++)
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    // Lowest invalid way wins over the PLRU choice
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w][w_idx]) w_victim = WAY_W'(w);
  end

  assign w_hit       = (r_state == IDLE) & (|w_hit_vec);
  assign w_miss      = (r_state == IDLE) & mem_read & ~(|w_hit_vec);
  assign w_fill_done = (r_state == FILL) & pmem_resp;
  assign w_clear_all = (flush & (r_state == IDLE))
                     | (w_fill_done & (r_flush_pend | flush));

  assign w_set     = (r_state == FILL) ? w_fill_idx : w_idx;
  assign w_acc_way = (r_state == FILL) ? r_victim : w_hit_way;

  icache_plru #(
    .WAYS(WAYS)
  ) u_plru (
    .i_tree  (r_plru[w_set]),
    .i_way   (w_acc_way),
    .o_tree  (w_plru_next),
    .o_victim(w_plru_victim)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_miss) w_next = FILL;
      FILL: if (pmem_resp) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_line_addr  <= '0;
      r_victim     <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '{default: '0};
      r_plru       <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_miss) begin
        r_line_addr <= line_addr(mem_address, S_OFFSET);
        r_victim    <= w_victim;
      end
      if (w_fill_done)
        r_flush_pend <= 1'b0;
      else if ((r_state == FILL) && flush)
        r_flush_pend <= 1'b1;
      if (w_clear_all)
        r_valid <= '{default: '0};
      else if (w_fill_done)
        r_valid[r_victim][w_fill_idx] <= 1'b1;
      if (w_hit || w_fill_done)
        r_plru[w_set] <= w_plru_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[r_victim][w_fill_idx] <= pmem_rdata;
      r_tag[r_victim][w_fill_idx]  <= w_fill_tag;
    end
  end

  assign mem_resp     = w_hit;
  assign mem_rdata256 = r_data[w_hit_way][w_idx];
  assign pmem_read    = (r_state == FILL);
  assign pmem_address = r_line_addr;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

`ifndef SYNTHESIS
  a_one_hit: assert property (
    @(posedge clk) disable iff (!rst) $onehot0(w_hit_vec)
  );
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: fills, hits, PLRU eviction, flush, reset.
// Counter checks compile in when ICACHE_PERF_CNT_EN is defined.
module tb_icache_nway;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mem_read = 1'b0;
  logic [31:0]  mem_address = '0;
  logic         mem_resp;
  logic [255:0] mem_rdata256;
  logic         flush = 1'b0;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   mem_cnt = 0;
  logic prev_pr = 1'b0;

  icache_nway dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_resp    (mem_resp),
    .mem_rdata256(mem_rdata256),
    .flush       (flush),
    .pmem_read   (pmem_read),
    .pmem_address(pmem_address),
    .pmem_rdata  (pmem_rdata),
`ifdef ICACHE_PERF_CNT_EN
    .hit_count   (hit_count),
    .miss_count  (miss_count),
`endif
    .pmem_resp   (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] la);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = (la ^ 32'hC0DE_0000) + 32'(i) * 32'h0101_0101;
    return r;
  endfunction

  // Memory: responds on the LAT-th cycle pmem_read is seen high
  always @(negedge clk) begin
    if (pmem_read && !prev_pr) req_cnt = req_cnt + 1;
    prev_pr = pmem_read;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_read) begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt == LAT) begin
        pmem_resp  = 1'b1;
        pmem_rdata = line_of(pmem_address);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // fcyc: cycle (1 = lookup cycle) in which flush is pulsed, 0 = none
  task automatic rd(input logic [31:0] a, input int fcyc, input int exp_cyc,
                    input int exp_fills, input string nm);
    logic [31:0]  la;
    logic [255:0] got_data;
    int           cyc;
    int           r0;
    bit           got;
    bit           bad_addr;
    la       = a & 32'hFFFF_FFE0;
    r0       = req_cnt;
    cyc      = 0;
    got      = 1'b0;
    bad_addr = 1'b0;
    got_data = '0;
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_address = a;
    flush       = (fcyc == 1);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pmem_read && pmem_address !== la) bad_addr = 1'b1;
      if (mem_resp === 1'b1) begin
        got      = 1'b1;
        got_data = mem_rdata256;
      end
      @(posedge clk); #1;
      flush = (cyc + 1 == fcyc);
    end
    mem_read = 1'b0;
    flush    = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s resp: no mem_resp within 40 cycles, expected one", nm);
    end
    checks++;
    if (got_data !== line_of(la)) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", nm, got_data, line_of(la));
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, cyc, exp_cyc);
    end
    checks++;
    if (req_cnt - r0 != exp_fills) begin
      errors++;
      $display("FAIL %s fills: got %0d expected %0d", nm, req_cnt - r0, exp_fills);
    end
    checks++;
    if (bad_addr) begin
      errors++;
      $display("FAIL %s pmem_address: deviated from expected %h", nm, la);
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: resp=%b pread=%b paddr=%h expected 0 0 0",
               mem_resp, pmem_read, pmem_address);
    end
`ifdef ICACHE_PERF_CNT_EN
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL reset counters: hit=%0d miss=%0d expected 0 0",
               hit_count, miss_count);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    rd(32'h0000_1040, 0, LAT + 2, 1, "cold_miss");
  endtask

  task automatic test_hit();
    rd(32'h0000_1048, 0, 1, 0, "hit");
    rd(32'h0000_105C, 0, 1, 0, "hit_last_word");
`ifdef ICACHE_PERF_CNT_EN
    checks++;
    if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
      errors++;
      $display("FAIL perf counters: hit=%0d miss=%0d expected 3 1",
               hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_flush_idle();
    rd(32'h0000_2000, 0, LAT + 2, 1, "fi_fill2");
    rd(32'h0000_1040, 1, 1, 0, "fi_hit_with_flush");
    rd(32'h0000_1040, 0, LAT + 2, 1, "fi_miss1");
    rd(32'h0000_2000, 0, LAT + 2, 1, "fi_miss2");
  endtask

  task automatic test_plru();
    pulse_flush();
    rd(32'h0001_0040, 0, LAT + 2, 1, "plru_fill_a");
    rd(32'h0002_0044, 0, LAT + 2, 1, "plru_fill_b");
    rd(32'h0003_0048, 0, LAT + 2, 1, "plru_fill_c");
    rd(32'h0004_0040, 0, LAT + 2, 1, "plru_fill_d");
    rd(32'h0001_0040, 0, 1, 0, "plru_touch_a");
    rd(32'h0003_0040, 0, 1, 0, "plru_touch_c");
    rd(32'h0005_0040, 0, LAT + 2, 1, "plru_fill_e");
    rd(32'h0001_0040, 0, 1, 0, "plru_a_kept");
    rd(32'h0003_0040, 0, 1, 0, "plru_c_kept");
    rd(32'h0004_0040, 0, 1, 0, "plru_d_kept");
    rd(32'h0005_0040, 0, 1, 0, "plru_e_hit");
    rd(32'h0002_0040, 0, LAT + 2, 1, "plru_b_evicted");
  endtask

  task automatic test_flush_fill();
    rd(32'h0000_3000, 2, 2 * LAT + 3, 2, "flush_in_fill");
    rd(32'h0000_3000, 0, 1, 0, "flush_in_fill_after");
    rd(32'h0000_3100, 4, 2 * LAT + 3, 2, "flush_with_resp");
    rd(32'h0000_3000, 0, LAT + 2, 1, "flush_with_resp_clr");
  endtask

  task automatic test_drop_during_fill();
    int r0;
    bit spurious;
    r0       = req_cnt;
    spurious = 1'b0;
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_address = 32'h0000_4000;
    @(posedge clk); #1;
    mem_read    = 1'b0;
    mem_address = 32'h0000_0000;
    repeat (6) begin
      @(negedge clk);
      if (mem_resp !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL drop resp: mem_resp seen after request dropped, expected 0");
    end
    checks++;
    if (req_cnt - r0 != 1) begin
      errors++;
      $display("FAIL drop fills: got %0d expected 1", req_cnt - r0);
    end
    rd(32'h0000_4000, 0, 1, 0, "drop_installed");
  endtask

  task automatic test_reset_mid_fill();
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_address = 32'h0000_5000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++;
      $display("FAIL rmf pread_before: got %b expected 1", pmem_read);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      errors++;
      $display("FAIL rmf async: pread=%b paddr=%h expected 0 00000000",
               pmem_read, pmem_address);
    end
    mem_read = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    checks++;
    if (miss_count !== 32'h0 || hit_count !== 32'h0) begin
      errors++;
      $display("FAIL rmf counters: hit=%0d miss=%0d expected 0 0",
               hit_count, miss_count);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    rd(32'h0000_5000, 0, LAT + 2, 1, "rmf_refetch");
    rd(32'h0000_1040, 0, LAT + 2, 1, "rmf_cold_again");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_flush_idle();
    test_plru();
    test_flush_fill();
    test_drop_during_fill();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
